// File: rtl/teachee_xadc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : teachee_xadc_pkg
// Brief    : Shared types and framing constants for the XADC frame sampler.
// Revision : 1.0 - initial release
// ============================================================================
package teachee_xadc_pkg;

    typedef enum logic [6:0] {
        CURRENT = 7'h14,
        VOLTAGE = 7'h1C
    } xadc_drp_addr_t;

    localparam logic [7:0] FRAME_SYNC = 8'hA5;
    localparam int         FRAME_LEN  = 5;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CUR_REQ   = 3'd1,
        CUR_WAIT  = 3'd2,
        VOLT_REQ  = 3'd3,
        VOLT_WAIT = 3'd4,
        SEND      = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axis_io.sv
`default_nettype none
// ============================================================================
// Module   : axis_io
// Brief    : Minimal AXI-Stream bundle (tdata/tvalid/tready).
// Revision : 1.0 - initial release
// ============================================================================
interface axis_io #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;

    modport Source (output tdata, output tvalid, input tready);
    modport Sink   (input tdata, input tvalid, output tready);
endinterface
`default_nettype wire

// File: rtl/xadc_drp_reader.sv
`default_nettype none
// ============================================================================
// Module   : xadc_drp_reader
// Brief    : One DRP read handshake with a drdy timeout; sample = do[15:4].
// Revision : 1.0 - initial release
// ============================================================================
module xadc_drp_reader
    import teachee_xadc_pkg::*;
#(
    parameter int DRP_TIMEOUT = 63
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  xadc_drp_addr_t addr,
    output logic [6:0]     xadc_daddr,
    output logic           xadc_den,
    input  logic           xadc_drdy,
    input  logic [15:0]    xadc_do,
    output logic           done,
    output logic [11:0]    data,
    output logic           timed_out
);
    localparam int                 c_cnt_w = $clog2(DRP_TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_limit = c_cnt_w'(DRP_TIMEOUT - 1);

    logic               r_busy;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_expired;
    logic               w_unused_lsbs;

    assign xadc_den      = start;
    assign xadc_daddr    = addr;
    assign w_unused_lsbs = ^xadc_do[3:0];

    // A drdy landing on the final counted cycle still wins over the timeout.
    assign w_expired = r_busy && !xadc_drdy && (r_cnt == c_limit);
    assign done      = r_busy && (xadc_drdy || w_expired);
    assign timed_out = w_expired;
    assign data      = w_expired ? 12'hFFF : xadc_do[15:4];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            if (done) begin
                r_busy <= 1'b0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xadc_frame_sampler.sv
`default_nettype none
// ============================================================================
// Module   : xadc_frame_sampler
// Brief    : Reads current/voltage over DRP on each EOS, streams 5-byte frames.
// Revision : 1.0 - initial release
// ============================================================================
module xadc_frame_sampler
    import teachee_xadc_pkg::*;
#(
    parameter int             DRP_TIMEOUT  = 63,
    parameter logic [7:0]     SYNC_BYTE    = FRAME_SYNC,
    parameter xadc_drp_addr_t CURRENT_ADDR = CURRENT,
    parameter xadc_drp_addr_t VOLTAGE_ADDR = VOLTAGE
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        xadc_eos,
    output logic [6:0]  xadc_daddr,
    output logic        xadc_den,
    input  logic        xadc_drdy,
    input  logic [15:0] xadc_do,
    axis_io.Source      m_axis,
    output logic [15:0] dropped_count,
    output logic        drp_timeout
);
    localparam logic [2:0] c_last_idx = 3'(FRAME_LEN - 1);

    state_t         r_state;
    state_t         w_next_state;
    logic [7:0]     r_seq;
    logic [7:0]     r_frame_seq;
    logic [11:0]    r_cur;
    logic [11:0]    r_volt;
    logic [2:0]     r_byte_idx;
    logic [15:0]    r_dropped;
    logic           r_timeout;

    logic           w_start;
    xadc_drp_addr_t w_addr;
    logic           w_done;
    logic [11:0]    w_data;
    logic           w_timed_out;
    logic           w_tvalid;
    logic [7:0]     w_tdata;

    xadc_drp_reader #(
        .DRP_TIMEOUT (DRP_TIMEOUT)
    ) u_drp_reader (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .addr       (w_addr),
        .xadc_daddr (xadc_daddr),
        .xadc_den   (xadc_den),
        .xadc_drdy  (xadc_drdy),
        .xadc_do    (xadc_do),
        .done       (w_done),
        .data       (w_data),
        .timed_out  (w_timed_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_addr       = CURRENT_ADDR;
        w_tvalid     = 1'b0;
        w_tdata      = '0;
        case (r_state)
            IDLE: begin
                if (xadc_eos) begin
                    w_next_state = CUR_REQ;
                end
            end
            CUR_REQ: begin
                w_start      = 1'b1;
                w_next_state = CUR_WAIT;
            end
            CUR_WAIT: begin
                if (w_done) begin
                    w_next_state = VOLT_REQ;
                end
            end
            VOLT_REQ: begin
                w_start      = 1'b1;
                w_addr       = VOLTAGE_ADDR;
                w_next_state = VOLT_WAIT;
            end
            VOLT_WAIT: begin
                w_addr = VOLTAGE_ADDR;
                if (w_done) begin
                    w_next_state = SEND;
                end
            end
            SEND: begin
                w_tvalid = 1'b1;
                case (r_byte_idx)
                    3'd0:    w_tdata = SYNC_BYTE;
                    3'd1:    w_tdata = r_frame_seq;
                    3'd2:    w_tdata = r_cur[11:4];
                    3'd3:    w_tdata = {r_cur[3:0], r_volt[11:8]};
                    default: w_tdata = r_volt[7:0];
                endcase
                if (m_axis.tready && (r_byte_idx == c_last_idx)) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // seq advances on every EOS so dropped sequences show up as gaps at the host.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq       <= '0;
            r_frame_seq <= '0;
            r_cur       <= '0;
            r_volt      <= '0;
            r_byte_idx  <= '0;
            r_dropped   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            if (xadc_eos) begin
                r_seq <= r_seq + 8'd1;
                if (r_state == IDLE) begin
                    r_frame_seq <= r_seq + 8'd1;
                end else if (r_dropped != 16'hFFFF) begin
                    r_dropped <= r_dropped + 16'd1;
                end
            end
            if (w_done && (r_state == CUR_WAIT)) begin
                r_cur <= w_data;
            end
            if (w_done && (r_state == VOLT_WAIT)) begin
                r_volt <= w_data;
            end
            if (w_done && w_timed_out) begin
                r_timeout <= 1'b1;
            end
            if (r_state != SEND) begin
                r_byte_idx <= '0;
            end else if (m_axis.tready) begin
                r_byte_idx <= r_byte_idx + 3'd1;
            end
        end
    end

    assign m_axis.tvalid = w_tvalid;
    assign m_axis.tdata  = w_tdata;
    assign dropped_count = r_dropped;
    assign drp_timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_xadc_frame_sampler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_xadc_frame_sampler
// Brief    : Scoreboard bench: XADC DRP responder, AXIS byte checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xadc_frame_sampler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        xadc_eos = 1'b0;
    logic        xadc_drdy = 1'b0;
    logic [15:0] xadc_do = 16'hDEAD;
    logic [6:0]  xadc_daddr;
    logic        xadc_den;
    logic [15:0] dropped_count;
    logic        drp_timeout;

    axis_io #(.DATA_W(8)) axis_if ();

    always #5 clk = ~clk;

    xadc_frame_sampler dut (
        .clk           (clk),
        .rst           (rst),
        .xadc_eos      (xadc_eos),
        .xadc_daddr    (xadc_daddr),
        .xadc_den      (xadc_den),
        .xadc_drdy     (xadc_drdy),
        .xadc_do       (xadc_do),
        .m_axis        (axis_if),
        .dropped_count (dropped_count),
        .drp_timeout   (drp_timeout)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  seq_model = 8'd0;
    logic [15:0] dropped_model = 16'd0;
    logic [15:0] cur_do = 16'h0000;
    logic [15:0] volt_do = 16'h0000;
    bit          withhold_volt = 1'b0;
    bit          toggle_mode = 1'b0;
    bit          exp_addr_volt = 1'b0;

    // DRP responder: answers each den three cycles later unless told to withhold.
    initial begin
        logic [6:0] exp_a;
        bit         got_volt;
        forever begin
            @(negedge clk);
            if (xadc_den === 1'b1) begin
                exp_a = exp_addr_volt ? 7'h1C : 7'h14;
                n_cmp++;
                if (xadc_daddr !== exp_a) begin
                    n_err++;
                    $display("FAIL drp_addr: daddr=%h required %h", xadc_daddr, exp_a);
                end
                got_volt      = (xadc_daddr === 7'h1C);
                exp_addr_volt = !exp_addr_volt;
                repeat (3) @(posedge clk);
                #1;
                if (!(got_volt && withhold_volt)) begin
                    xadc_drdy = 1'b1;
                    xadc_do   = got_volt ? volt_do : cur_do;
                    @(posedge clk);
                    #1;
                    xadc_drdy = 1'b0;
                    xadc_do   = 16'hDEAD;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode) axis_if.tready = ~axis_if.tready;
        end
    end

    // AXIS monitor: pops the scoreboard on each handshake and checks stall hold.
    initial begin
        logic       prev_stall;
        logic       prev_rst;
        logic [7:0] prev_data;
        logic [7:0] exp_b;
        prev_stall = 1'b0;
        prev_rst   = 1'b1;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (prev_stall && !prev_rst) begin
                n_cmp++;
                if (axis_if.tvalid !== 1'b1 || axis_if.tdata !== prev_data) begin
                    n_err++;
                    $display("FAIL stall_hold: tvalid=%b tdata=%h required tvalid=1 tdata=%h",
                             axis_if.tvalid, axis_if.tdata, prev_data);
                end
            end
            if (axis_if.tvalid === 1'b1 && axis_if.tready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_byte: tdata=%h required no byte", axis_if.tdata);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (axis_if.tdata !== exp_b) begin
                        n_err++;
                        $display("FAIL frame_byte: tdata=%h required %h", axis_if.tdata, exp_b);
                    end
                end
            end
            prev_stall = (axis_if.tvalid === 1'b1) && (axis_if.tready === 1'b0);
            prev_data  = axis_if.tdata;
            prev_rst   = rst;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    task automatic send_eos(input bit accept);
        logic [11:0] c;
        logic [11:0] v;
        @(posedge clk);
        #1 xadc_eos = 1'b1;
        @(posedge clk);
        #1 xadc_eos = 1'b0;
        seq_model = seq_model + 8'd1;
        if (accept) begin
            c = cur_do[15:4];
            v = withhold_volt ? 12'hFFF : volt_do[15:4];
            exp_q.push_back(8'hA5);
            exp_q.push_back(seq_model);
            exp_q.push_back(c[11:4]);
            exp_q.push_back({c[3:0], v[11:8]});
            exp_q.push_back(v[7:0]);
        end else begin
            dropped_model = dropped_model + 16'd1;
        end
    endtask

    task automatic wait_valid();
        int k;
        k = 0;
        @(negedge clk);
        while (axis_if.tvalid !== 1'b1 && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (k >= 300) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_valid: tvalid=%b required 1 within 300 cycles", axis_if.tvalid);
        end
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || axis_if.tvalid !== 1'b0) && k < 500) begin
            @(negedge clk);
            k++;
        end
        if (k >= 500) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_drain: pending=%0d tvalid=%b required 0/0 within 500 cycles",
                     exp_q.size(), axis_if.tvalid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (xadc_den !== 1'b0 || xadc_daddr !== 7'h14 || axis_if.tvalid !== 1'b0 ||
            axis_if.tdata !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: den=%b daddr=%h tvalid=%b tdata=%h required 0/14/0/00",
                     xadc_den, xadc_daddr, axis_if.tvalid, axis_if.tdata);
        end
        n_cmp++;
        if (dropped_count !== 16'd0 || drp_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL reset_status: dropped=%h timeout=%b required 0000/0",
                     dropped_count, drp_timeout);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic();
        cur_do  = 16'hABC0;
        volt_do = 16'h1230;
        send_eos(1'b1);
        wait_valid();
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (axis_if.tvalid !== 1'b1) begin
                n_err++;
                $display("FAIL back_to_back_byte%0d: tvalid=%b required 1", i, axis_if.tvalid);
            end
            @(negedge clk);
        end
        n_cmp++;
        if (axis_if.tvalid !== 1'b0) begin
            n_err++;
            $display("FAIL frame_end: tvalid=%b required 0", axis_if.tvalid);
        end
        wait_drain();
    endtask

    task automatic test_stall_toggle();
        cur_do  = 16'hABC0;
        volt_do = 16'h1230;
        toggle_mode = 1'b1;
        send_eos(1'b1);
        wait_drain();
        toggle_mode = 1'b0;
        @(posedge clk);
        #1 axis_if.tready = 1'b1;
    endtask

    task automatic test_drops();
        cur_do  = 16'h5A70;
        volt_do = 16'h0E10;
        @(posedge clk);
        #1 axis_if.tready = 1'b0;
        send_eos(1'b1);
        wait_valid();
        for (int i = 0; i < 3; i++) send_eos(1'b0);
        @(negedge clk);
        n_cmp++;
        if (dropped_count !== dropped_model) begin
            n_err++;
            $display("FAIL dropped_count: %h required %h", dropped_count, dropped_model);
        end
        @(posedge clk);
        #1 axis_if.tready = 1'b1;
        wait_drain();
        cur_do  = 16'h1110;
        volt_do = 16'h2220;
        send_eos(1'b1);
        wait_drain();
    endtask

    task automatic test_timeout();
        @(negedge clk);
        n_cmp++;
        if (drp_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_pre: drp_timeout=%b required 0", drp_timeout);
        end
        cur_do        = 16'h3C50;
        withhold_volt = 1'b1;
        send_eos(1'b1);
        wait_drain();
        withhold_volt = 1'b0;
        n_cmp++;
        if (drp_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_set: drp_timeout=%b required 1", drp_timeout);
        end
        cur_do  = 16'h7770;
        volt_do = 16'h8880;
        send_eos(1'b1);
        wait_drain();
        n_cmp++;
        if (drp_timeout !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_sticky: drp_timeout=%b required 1", drp_timeout);
        end
    endtask

    task automatic test_reset_mid_frame();
        cur_do  = 16'h4440;
        volt_do = 16'h5550;
        @(posedge clk);
        #1 axis_if.tready = 1'b0;
        send_eos(1'b1);
        wait_valid();
        @(posedge clk);
        #1 axis_if.tready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        axis_if.tready = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        seq_model     = 8'd0;
        dropped_model = 16'd0;
        @(negedge clk);
        n_cmp++;
        if (axis_if.tvalid !== 1'b0 || axis_if.tdata !== 8'h00 || xadc_den !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_reset_axis: tvalid=%b tdata=%h den=%b required 0/00/0",
                     axis_if.tvalid, axis_if.tdata, xadc_den);
        end
        n_cmp++;
        if (dropped_count !== 16'd0 || drp_timeout !== 1'b0) begin
            n_err++;
            $display("FAIL midframe_reset_status: dropped=%h timeout=%b required 0000/0",
                     dropped_count, drp_timeout);
        end
        @(posedge clk);
        #1 axis_if.tready = 1'b1;
        send_eos(1'b1);
        wait_drain();
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 256; f++) begin
            cur_do  = 16'($urandom);
            volt_do = 16'($urandom);
            send_eos(1'b1);
            wait_drain();
        end
    endtask

    initial begin
        axis_if.tready = 1'b1;
        test_reset();
        test_basic();
        test_stall_toggle();
        test_drops();
        test_timeout();
        test_reset_mid_frame();
        test_back_to_back();
        repeat (5) @(posedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL leftover: pending=%0d required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
